// File: rtl/udp_stream_parser_pkg.sv
// Shared types and constants for the Ethernet/IPv4/UDP stream parser:
// FSM state encoding, header lengths, protocol defaults and field byte offsets.
package udp_parser_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ETH_HDR,
        S_IP_HDR,
        S_UDP_HDR,
        S_PAYLOAD,
        S_DRAIN
    } parser_state_t;

    localparam logic [15:0] ETH_HDR_LEN    = 16'd14;
    localparam logic [15:0] IP_HDR_MIN_LEN = 16'd20;
    localparam logic [15:0] UDP_HDR_LEN    = 16'd8;

    localparam logic [15:0] ETH_TYPE_IPV4_DFLT = 16'h0800;
    localparam logic [3:0]  IP_VERSION_DFLT    = 4'h4;
    localparam logic [7:0]  UDP_PROTOCOL_DFLT  = 8'h11;

    // Byte offsets within each header layer
    localparam logic [15:0] ETH_TYPE_OFS = 16'd12;
    localparam logic [15:0] IP_PROTO_OFS = 16'd9;
    localparam logic [15:0] IP_SRC_OFS   = 16'd12;
    localparam logic [15:0] IP_DST_OFS   = 16'd16;
    localparam logic [15:0] UDP_SRC_OFS  = 16'd0;
    localparam logic [15:0] UDP_DST_OFS  = 16'd2;
    localparam logic [15:0] UDP_LEN_OFS  = 16'd4;

endpackage

// File: rtl/udp_stream_parser_csum.sv
// Byte-serial ones-complement accumulator for the IPv4 header checksum.
// Only built when UDP_PARSER_IP_CSUM_EN is defined.
`ifdef UDP_PARSER_IP_CSUM_EN
module ip_csum_acc (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] byte_in,
    output logic       sum_ok
);

    logic [15:0] sum;
    logic [7:0]  hi_byte;
    logic        odd;
    logic [16:0] raw;
    logic [15:0] folded;

    // sum_ok looks ahead at the word completed by the current low byte,
    // so it is valid on the cycle the last header byte is presented.
    assign raw    = {1'b0, sum} + {1'b0, hi_byte, byte_in};
    assign folded = raw[15:0] + {15'd0, raw[16]};
    assign sum_ok = odd && (folded == 16'hFFFF);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum     <= 16'd0;
            hi_byte <= 8'd0;
            odd     <= 1'b0;
        end else if (clear) begin
            sum     <= 16'd0;
            hi_byte <= 8'd0;
            odd     <= 1'b0;
        end else if (en) begin
            if (!odd) begin
                hi_byte <= byte_in;
                odd     <= 1'b1;
            end else begin
                sum <= folded;
                odd <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/udp_stream_parser.sv
// Ethernet/IPv4/UDP byte-stream parser: validates headers, publishes fields and
// forwards only the UDP payload. Optional IPv4 checksum check: UDP_PARSER_IP_CSUM_EN.
module udp_stream_parser
    import udp_parser_pkg::*;
#(
    parameter logic [15:0] ETH_TYPE_IPV4    = ETH_TYPE_IPV4_DFLT,
    parameter logic [3:0]  IP_VERSION_DEF   = IP_VERSION_DFLT,
    parameter logic [7:0]  UDP_PROTOCOL_DEF = UDP_PROTOCOL_DFLT,
    parameter int          CNT_WIDTH        = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           din,
    input  logic                 in_sof,
    input  logic                 in_eof,
    input  logic                 in_empty,
    output logic                 in_rd_en,
    input  logic                 out_full,
    output logic                 out_wr_en,
    output logic [7:0]           out_dout,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic                 hdr_valid,
    output logic [31:0]          ip_src,
    output logic [31:0]          ip_dst,
    output logic [15:0]          udp_src_port,
    output logic [15:0]          udp_dst_port,
    output logic [15:0]          udp_len,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output parser_state_t        fsm_state
);

    parser_state_t state;
    logic [15:0]   byte_cnt;
    logic [5:0]    ip_len;
    logic [15:0]   pay_len;
    logic [7:0]    eth_type_hi;
    logic [31:0]   ip_src_sh, ip_dst_sh;
    logic [15:0]   sport_sh, dport_sh, ulen_sh;
    logic          hdr_last, hdr_reject, pay_last, csum_ok;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Handshake: a byte moves whenever the source is non-empty; only the payload
    // path waits for downstream space. Writes are never issued without a pop.
    assign in_rd_en  = !reset && !in_empty && (state != S_PAYLOAD || !out_full);
    assign pay_last  = (byte_cnt == pay_len - 16'd1);
    assign out_wr_en = in_rd_en && (state == S_PAYLOAD) && !in_sof;
    assign out_dout  = (state == S_PAYLOAD) ? din : 8'h00;
    assign out_sof   = out_wr_en && (byte_cnt == 16'd0);
    assign out_eof   = out_wr_en && (pay_last || in_eof);
    assign fsm_state = state;

`ifdef UDP_PARSER_IP_CSUM_EN
    ip_csum_acc u_csum (
        .clock   (clock),
        .reset   (reset),
        .clear   (state != S_IP_HDR),
        .en      (in_rd_en && (state == S_IP_HDR)),
        .byte_in (din),
        .sum_ok  (csum_ok)
    );
`else
    assign csum_ok = 1'b1;
`endif

    always_comb begin
        hdr_last   = 1'b0;
        hdr_reject = 1'b0;
        case (state)
            S_ETH_HDR: begin
                hdr_last   = (byte_cnt == ETH_HDR_LEN - 16'd1);
                hdr_reject = hdr_last && ({eth_type_hi, din} != ETH_TYPE_IPV4);
            end
            S_IP_HDR: begin
                hdr_last = (byte_cnt == {10'd0, ip_len} - 16'd1);
                if (byte_cnt == 16'd0)
                    hdr_reject = (din[7:4] != IP_VERSION_DEF) ||
                                 ({10'd0, din[3:0], 2'b00} < IP_HDR_MIN_LEN);
                else if (byte_cnt == IP_PROTO_OFS)
                    hdr_reject = (din != UDP_PROTOCOL_DEF);
                else if (hdr_last)
                    hdr_reject = !csum_ok;
            end
            S_UDP_HDR: begin
                hdr_last = (byte_cnt == UDP_HDR_LEN - 16'd1);
                if (byte_cnt == UDP_LEN_OFS + 16'd1)
                    hdr_reject = ({ulen_sh[15:8], din} < UDP_HDR_LEN);
            end
            default: ;
        endcase
    end

    // Shadow copies collect fields while the header streams in; they are only
    // published once the whole header has been accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            eth_type_hi <= 8'd0;
            ip_len      <= 6'd0;
            ip_src_sh   <= 32'd0;
            ip_dst_sh   <= 32'd0;
            sport_sh    <= 16'd0;
            dport_sh    <= 16'd0;
            ulen_sh     <= 16'd0;
        end else if (in_rd_en) begin
            if (state == S_ETH_HDR && byte_cnt == ETH_TYPE_OFS)
                eth_type_hi <= din;
            if (state == S_IP_HDR) begin
                if (byte_cnt == 16'd0)
                    ip_len <= {din[3:0], 2'b00};
                if (byte_cnt >= IP_SRC_OFS && byte_cnt < IP_SRC_OFS + 16'd4)
                    ip_src_sh <= {ip_src_sh[23:0], din};
                if (byte_cnt >= IP_DST_OFS && byte_cnt < IP_DST_OFS + 16'd4)
                    ip_dst_sh <= {ip_dst_sh[23:0], din};
            end
            if (state == S_UDP_HDR) begin
                if (byte_cnt >= UDP_SRC_OFS && byte_cnt < UDP_SRC_OFS + 16'd2)
                    sport_sh <= {sport_sh[7:0], din};
                if (byte_cnt >= UDP_DST_OFS && byte_cnt < UDP_DST_OFS + 16'd2)
                    dport_sh <= {dport_sh[7:0], din};
                if (byte_cnt >= UDP_LEN_OFS && byte_cnt < UDP_LEN_OFS + 16'd2)
                    ulen_sh <= {ulen_sh[7:0], din};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            byte_cnt     <= 16'd0;
            pay_len      <= 16'd0;
            hdr_valid    <= 1'b0;
            ip_src       <= 32'd0;
            ip_dst       <= 32'd0;
            udp_src_port <= 16'd0;
            udp_dst_port <= 16'd0;
            udp_len      <= 16'd0;
            frame_count  <= '0;
            drop_count   <= '0;
            err_count    <= '0;
        end else begin
            hdr_valid <= 1'b0;
            if (in_rd_en) begin
                if (in_sof && state != S_IDLE) begin
                    // A new frame start aborts whatever was in progress
                    err_count <= sat_inc(err_count);
                    state     <= in_eof ? S_IDLE : S_ETH_HDR;
                    byte_cnt  <= in_eof ? 16'd0 : 16'd1;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (in_sof) begin
                                if (in_eof) begin
                                    err_count <= sat_inc(err_count);
                                end else begin
                                    state    <= S_ETH_HDR;
                                    byte_cnt <= 16'd1;
                                end
                            end
                        end
                        S_ETH_HDR, S_IP_HDR, S_UDP_HDR: begin
                            if (hdr_reject) begin
                                drop_count <= sat_inc(drop_count);
                                state      <= in_eof ? S_IDLE : S_DRAIN;
                                byte_cnt   <= 16'd0;
                            end else if (hdr_last) begin
                                byte_cnt <= 16'd0;
                                if (state == S_ETH_HDR || state == S_IP_HDR) begin
                                    if (in_eof) begin
                                        err_count <= sat_inc(err_count);
                                        state     <= S_IDLE;
                                    end else begin
                                        state <= (state == S_ETH_HDR) ? S_IP_HDR : S_UDP_HDR;
                                    end
                                end else begin
                                    hdr_valid    <= 1'b1;
                                    frame_count  <= sat_inc(frame_count);
                                    ip_src       <= ip_src_sh;
                                    ip_dst       <= ip_dst_sh;
                                    udp_src_port <= sport_sh;
                                    udp_dst_port <= dport_sh;
                                    udp_len      <= ulen_sh;
                                    pay_len      <= ulen_sh - UDP_HDR_LEN;
                                    if (in_eof) begin
                                        if (ulen_sh != UDP_HDR_LEN)
                                            err_count <= sat_inc(err_count);
                                        state <= S_IDLE;
                                    end else begin
                                        state <= (ulen_sh == UDP_HDR_LEN) ? S_DRAIN : S_PAYLOAD;
                                    end
                                end
                            end else if (in_eof) begin
                                err_count <= sat_inc(err_count);
                                state     <= S_IDLE;
                                byte_cnt  <= 16'd0;
                            end else begin
                                byte_cnt <= byte_cnt + 16'd1;
                            end
                        end
                        S_PAYLOAD: begin
                            if (pay_last || in_eof) begin
                                if (in_eof && !pay_last)
                                    err_count <= sat_inc(err_count);
                                state    <= in_eof ? S_IDLE : S_DRAIN;
                                byte_cnt <= 16'd0;
                            end else begin
                                byte_cnt <= byte_cnt + 16'd1;
                            end
                        end
                        default: begin
                            if (in_eof)
                                state <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_stream_parser.sv
// Directed self-checking bench for udp_stream_parser; the checksum scenario
// follows UDP_PARSER_IP_CSUM_EN.
module tb_udp_stream_parser;
    import udp_parser_pkg::*;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    din = 8'h00;
    logic          in_sof = 1'b0, in_eof = 1'b0, in_empty = 1'b1;
    logic          in_rd_en;
    logic          out_full = 1'b0;
    logic          out_wr_en, out_sof, out_eof, hdr_valid;
    logic [7:0]    out_dout;
    logic [31:0]   ip_src, ip_dst;
    logic [15:0]   udp_src_port, udp_dst_port, udp_len;
    logic [15:0]   frame_count, drop_count, err_count;
    parser_state_t fsm_state;

    always #5 clock = ~clock;

    udp_stream_parser dut (
        .clock(clock), .reset(reset), .din(din), .in_sof(in_sof), .in_eof(in_eof),
        .in_empty(in_empty), .in_rd_en(in_rd_en), .out_full(out_full),
        .out_wr_en(out_wr_en), .out_dout(out_dout), .out_sof(out_sof), .out_eof(out_eof),
        .hdr_valid(hdr_valid), .ip_src(ip_src), .ip_dst(ip_dst),
        .udp_src_port(udp_src_port), .udp_dst_port(udp_dst_port), .udp_len(udp_len),
        .frame_count(frame_count), .drop_count(drop_count), .err_count(err_count),
        .fsm_state(fsm_state)
    );

    int         compared = 0;
    int         mismatched = 0;
    int         hdr_pulses = 0;
    int         exp_frames = 0, exp_drops = 0, exp_errs = 0;
    logic       took = 1'b0;
    logic [9:0] in_q[$];   // {sof, eof, byte}
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    logic [7:0] pay[16];

    // Source FIFO model and output capture: inputs change on the falling edge,
    // outputs are sampled 1ns later and consumed at the following rising edge.
    initial begin
        forever begin
            @(negedge clock);
            if (took && in_q.size() > 0) void'(in_q.pop_front());
            if (in_q.size() > 0) begin
                {in_sof, in_eof, din} = in_q[0];
                in_empty = 1'b0;
            end else begin
                {in_sof, in_eof, din} = 10'd0;
                in_empty = 1'b1;
            end
            #1;
            took = in_rd_en;
            if (out_wr_en) got_q.push_back({out_sof, out_eof, out_dout});
            if (hdr_valid) hdr_pulses++;
        end
    end

    function automatic logic [15:0] csum16(input logic [7:0] b[$], input int start, input int len);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < len; i += 2) s += {16'd0, b[start+i], b[start+i+1]};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return ~s[15:0];
    endfunction

    // ip_src = 0A00:sport, ip_dst = C0A8:dport; cut>0 ends the frame early.
    task automatic send_frame(input logic [15:0] etype, input int ihl, input logic [15:0] sport,
                              input logic [15:0] dport, input logic [15:0] ulen, input int npay,
                              input int npad, input logic [15:0] delta, input int cut);
        logic [7:0]  fb[$];
        logic [15:0] cs, tot;
        int          n;
        for (int i = 0; i < 6; i++) fb.push_back(8'hFF);
        for (int i = 0; i < 6; i++) fb.push_back(8'h02 + 8'(i));
        fb.push_back(etype[15:8]); fb.push_back(etype[7:0]);
        tot = 16'(ihl * 4) + ulen;
        fb.push_back({4'h4, 4'(ihl)}); fb.push_back(8'h00);
        fb.push_back(tot[15:8]); fb.push_back(tot[7:0]);
        fb.push_back(8'h12); fb.push_back(8'h34); fb.push_back(8'h00); fb.push_back(8'h00);
        fb.push_back(8'h40); fb.push_back(8'h11); fb.push_back(8'h00); fb.push_back(8'h00);
        fb.push_back(8'h0A); fb.push_back(8'h00); fb.push_back(sport[15:8]); fb.push_back(sport[7:0]);
        fb.push_back(8'hC0); fb.push_back(8'hA8); fb.push_back(dport[15:8]); fb.push_back(dport[7:0]);
        for (int i = 0; i < (ihl - 5) * 4; i++) fb.push_back(8'h01);
        cs = csum16(fb, 14, ihl * 4) + delta;
        fb[24] = cs[15:8];
        fb[25] = cs[7:0];
        fb.push_back(sport[15:8]); fb.push_back(sport[7:0]);
        fb.push_back(dport[15:8]); fb.push_back(dport[7:0]);
        fb.push_back(ulen[15:8]);  fb.push_back(ulen[7:0]);
        fb.push_back(8'h00);       fb.push_back(8'h00);
        for (int i = 0; i < npay; i++) fb.push_back(pay[i]);
        for (int i = 0; i < npad; i++) fb.push_back(8'h00);
        n = (cut > 0) ? cut : fb.size();
        for (int i = 0; i < n; i++) in_q.push_back({(i == 0), (i == n - 1), fb[i]});
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (in_q.size() != 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        compared++;
        if (in_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s_timeout: %0d bytes left, expected 0", name, in_q.size());
        end
    endtask

    task automatic start_test();
        got_q.delete();
        exp_q.delete();
        hdr_pulses = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_q.push_back({2'b00, 8'h55});
        repeat (3) @(negedge clock);
        #2;
        compared += 7;
        if (in_rd_en !== 1'b0) begin mismatched++; $display("FAIL reset_rd_en: got %b expected 0", in_rd_en); end
        if ({out_wr_en, out_sof, out_eof, hdr_valid} !== 4'b0) begin mismatched++; $display("FAIL reset_out_flags: got %b expected 0000", {out_wr_en, out_sof, out_eof, hdr_valid}); end
        if (out_dout !== 8'h00) begin mismatched++; $display("FAIL reset_dout: got %h expected 00", out_dout); end
        if ({frame_count, drop_count, err_count} !== 48'd0) begin mismatched++; $display("FAIL reset_counters: got %h expected 0", {frame_count, drop_count, err_count}); end
        if ({ip_src, ip_dst} !== 64'd0) begin mismatched++; $display("FAIL reset_ip: got %h expected 0", {ip_src, ip_dst}); end
        if ({udp_src_port, udp_dst_port, udp_len} !== 48'd0) begin mismatched++; $display("FAIL reset_udp: got %h expected 0", {udp_src_port, udp_dst_port, udp_len}); end
        if (fsm_state !== S_IDLE) begin mismatched++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, S_IDLE); end
        reset = 1'b0;
        wait_drain("reset");
    endtask

    task automatic test_valid_frame();
        start_test();
        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
        send_frame(16'h0800, 5, 16'h1111, 16'h2222, 16'h000C, 4, 14, 16'h0000, 0);
        wait_drain("valid");
        exp_frames++;
        exp_q.push_back({2'b10, 8'hDE}); exp_q.push_back({2'b00, 8'hAD});
        exp_q.push_back({2'b00, 8'hBE}); exp_q.push_back({2'b01, 8'hEF});
        compared += 6;
        if (hdr_pulses != 1) begin mismatched++; $display("FAIL valid_hdr_pulses: got %0d expected 1", hdr_pulses); end
        if (frame_count !== 16'(exp_frames)) begin mismatched++; $display("FAIL valid_frame_count: got %0d expected %0d", frame_count, exp_frames); end
        if (ip_src !== 32'h0A001111) begin mismatched++; $display("FAIL valid_ip_src: got %h expected 0a001111", ip_src); end
        if (ip_dst !== 32'hC0A82222) begin mismatched++; $display("FAIL valid_ip_dst: got %h expected c0a82222", ip_dst); end
        if ({udp_src_port, udp_dst_port, udp_len} !== {16'h1111, 16'h2222, 16'h000C}) begin mismatched++; $display("FAIL valid_udp: got %h expected 11112222000c", {udp_src_port, udp_dst_port, udp_len}); end
        if (got_q.size() != exp_q.size()) begin mismatched++; $display("FAIL valid_pay_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL valid_pay[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_bad_ethertype();
        start_test();
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        send_frame(16'h86DD, 5, 16'h0101, 16'h0202, 16'h000C, 4, 0, 16'h0000, 0);
        send_frame(16'h0800, 5, 16'h0303, 16'h0404, 16'h000C, 4, 0, 16'h0000, 0);
        wait_drain("ethertype");
        exp_drops++;
        exp_frames++;
        exp_q.push_back({2'b10, 8'h01}); exp_q.push_back({2'b00, 8'h02});
        exp_q.push_back({2'b00, 8'h03}); exp_q.push_back({2'b01, 8'h04});
        compared += 5;
        if (drop_count !== 16'(exp_drops)) begin mismatched++; $display("FAIL etype_drop_count: got %0d expected %0d", drop_count, exp_drops); end
        if (frame_count !== 16'(exp_frames)) begin mismatched++; $display("FAIL etype_frame_count: got %0d expected %0d", frame_count, exp_frames); end
        if (hdr_pulses != 1) begin mismatched++; $display("FAIL etype_hdr_pulses: got %0d expected 1", hdr_pulses); end
        if (udp_src_port !== 16'h0303) begin mismatched++; $display("FAIL etype_next_port: got %h expected 0303", udp_src_port); end
        if (got_q.size() != exp_q.size()) begin mismatched++; $display("FAIL etype_pay_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL etype_pay[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_ip_options();
        start_test();
        pay[0] = 8'h5A; pay[1] = 8'hA5;
        send_frame(16'h0800, 6, 16'hABCD, 16'h0035, 16'h000A, 2, 6, 16'h0000, 0);
        wait_drain("options");
        exp_frames++;
        exp_q.push_back({2'b10, 8'h5A}); exp_q.push_back({2'b01, 8'hA5});
        compared += 5;
        if (ip_src !== 32'h0A00ABCD) begin mismatched++; $display("FAIL opt_ip_src: got %h expected 0a00abcd", ip_src); end
        if (ip_dst !== 32'hC0A80035) begin mismatched++; $display("FAIL opt_ip_dst: got %h expected c0a80035", ip_dst); end
        if ({udp_src_port, udp_dst_port, udp_len} !== {16'hABCD, 16'h0035, 16'h000A}) begin mismatched++; $display("FAIL opt_udp: got %h expected abcd0035000a", {udp_src_port, udp_dst_port, udp_len}); end
        if (frame_count !== 16'(exp_frames)) begin mismatched++; $display("FAIL opt_frame_count: got %0d expected %0d", frame_count, exp_frames); end
        if (got_q.size() != exp_q.size()) begin mismatched++; $display("FAIL opt_pay_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL opt_pay[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        start_test();
        for (int i = 0; i < 10; i++) pay[i] = 8'h30 + 8'(i);
        send_frame(16'h0800, 5, 16'h1000, 16'h2000, 16'd18, 10, 0, 16'h0000, 0);
        while (got_q.size() < 3 && n < 500) begin
            @(negedge clock);
            n++;
        end
        compared++;
        if (got_q.size() < 3) begin mismatched++; $display("FAIL bp_reach_payload: got %0d bytes expected 3", got_q.size()); end
        out_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            compared++;
            if ({in_rd_en, out_wr_en} !== 2'b00) begin mismatched++; $display("FAIL bp_stall_%0d: got rd/wr %b expected 00", c, {in_rd_en, out_wr_en}); end
            @(negedge clock);
        end
        out_full = 1'b0;
        wait_drain("backpressure");
        exp_frames++;
        for (int i = 0; i < 10; i++) exp_q.push_back({(i == 0), (i == 9), 8'h30 + 8'(i)});
        compared += 2;
        if (frame_count !== 16'(exp_frames)) begin mismatched++; $display("FAIL bp_frame_count: got %0d expected %0d", frame_count, exp_frames); end
        if (got_q.size() != exp_q.size()) begin mismatched++; $display("FAIL bp_pay_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL bp_pay[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_truncation();
        start_test();
        pay[0] = 8'h71; pay[1] = 8'h72; pay[2] = 8'h73;
        send_frame(16'h0800, 5, 16'h0007, 16'h0008, 16'd20, 3, 0, 16'h0000, 0);
        wait_drain("truncation");
        exp_frames++;
        exp_errs++;
        exp_q.push_back({2'b10, 8'h71}); exp_q.push_back({2'b00, 8'h72}); exp_q.push_back({2'b01, 8'h73});
        compared += 4;
        if (err_count !== 16'(exp_errs)) begin mismatched++; $display("FAIL trunc_err_count: got %0d expected %0d", err_count, exp_errs); end
        if (frame_count !== 16'(exp_frames)) begin mismatched++; $display("FAIL trunc_frame_count: got %0d expected %0d", frame_count, exp_frames); end
        if (udp_len !== 16'd20) begin mismatched++; $display("FAIL trunc_udp_len: got %0d expected 20", udp_len); end
        if (got_q.size() != exp_q.size()) begin mismatched++; $display("FAIL trunc_pay_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL trunc_pay[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_bad_checksum();
        start_test();
        pay[0] = 8'hC1; pay[1] = 8'hC2; pay[2] = 8'hC3; pay[3] = 8'hC4;
        send_frame(16'h0800, 5, 16'h0C0C, 16'h0D0D, 16'h000C, 4, 2, 16'h0001, 0);
        wait_drain("checksum");
        int_expect_csum();
        compared += 4;
        if (drop_count !== 16'(exp_drops)) begin mismatched++; $display("FAIL csum_drop_count: got %0d expected %0d", drop_count, exp_drops); end
        if (frame_count !== 16'(exp_frames)) begin mismatched++; $display("FAIL csum_frame_count: got %0d expected %0d", frame_count, exp_frames); end
        if (hdr_pulses != exp_q.size() / 4) begin mismatched++; $display("FAIL csum_hdr_pulses: got %0d expected %0d", hdr_pulses, exp_q.size() / 4); end
        if (got_q.size() != exp_q.size()) begin mismatched++; $display("FAIL csum_pay_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL csum_pay[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic int_expect_csum();
`ifdef UDP_PARSER_IP_CSUM_EN
        exp_drops++;
`else
        exp_frames++;
        exp_q.push_back({2'b10, 8'hC1}); exp_q.push_back({2'b00, 8'hC2});
        exp_q.push_back({2'b00, 8'hC3}); exp_q.push_back({2'b01, 8'hC4});
`endif
    endtask

    task automatic test_sof_abort();
        start_test();
        for (int i = 0; i < 8; i++) pay[i] = 8'hA0 + 8'(i);
        send_frame(16'h0800, 5, 16'h3333, 16'h4444, 16'd16, 8, 0, 16'h0000, 44);
        in_q[in_q.size() - 1][8] = 1'b0;
        send_frame(16'h0800, 5, 16'h5555, 16'h6666, 16'h000C, 4, 0, 16'h0000, 0);
        wait_drain("sof_abort");
        exp_frames += 2;
        exp_errs++;
        exp_q.push_back({2'b10, 8'hA0}); exp_q.push_back({2'b00, 8'hA1});
        exp_q.push_back({2'b10, 8'hA0}); exp_q.push_back({2'b00, 8'hA1});
        exp_q.push_back({2'b00, 8'hA2}); exp_q.push_back({2'b01, 8'hA3});
        compared += 5;
        if (err_count !== 16'(exp_errs)) begin mismatched++; $display("FAIL abort_err_count: got %0d expected %0d", err_count, exp_errs); end
        if (frame_count !== 16'(exp_frames)) begin mismatched++; $display("FAIL abort_frame_count: got %0d expected %0d", frame_count, exp_frames); end
        if (hdr_pulses != 2) begin mismatched++; $display("FAIL abort_hdr_pulses: got %0d expected 2", hdr_pulses); end
        if (udp_dst_port !== 16'h6666) begin mismatched++; $display("FAIL abort_port: got %h expected 6666", udp_dst_port); end
        if (got_q.size() != exp_q.size()) begin mismatched++; $display("FAIL abort_pay_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL abort_pay[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        start_test();
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        send_frame(16'h0800, 5, 16'h7777, 16'h8888, 16'h000C, 4, 0, 16'h0000, 0);
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #2;
        compared += 2;
        if (fsm_state !== S_IDLE) begin mismatched++; $display("FAIL midreset_state: got %0d expected %0d", fsm_state, S_IDLE); end
        if ({frame_count, drop_count, err_count} !== 48'd0) begin mismatched++; $display("FAIL midreset_counters: got %h expected 0", {frame_count, drop_count, err_count}); end
        @(negedge clock);
        reset = 1'b0;
        wait_drain("midreset_discard");
        send_frame(16'h0800, 5, 16'h9999, 16'hAAAA, 16'h000C, 4, 0, 16'h0000, 0);
        wait_drain("midreset_next");
        exp_q.push_back({2'b10, 8'h11}); exp_q.push_back({2'b00, 8'h22});
        exp_q.push_back({2'b00, 8'h33}); exp_q.push_back({2'b01, 8'h44});
        compared += 4;
        if (frame_count !== 16'd1) begin mismatched++; $display("FAIL midreset_frame_count: got %0d expected 1", frame_count); end
        if ({drop_count, err_count} !== 32'd0) begin mismatched++; $display("FAIL midreset_drop_err: got %h expected 0", {drop_count, err_count}); end
        if (udp_src_port !== 16'h9999) begin mismatched++; $display("FAIL midreset_port: got %h expected 9999", udp_src_port); end
        if (got_q.size() != exp_q.size()) begin mismatched++; $display("FAIL midreset_pay_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL midreset_pay[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_ethertype();
        test_ip_options();
        test_backpressure();
        test_truncation();
        test_bad_checksum();
        test_sof_abort();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
